// File: rtl/card_dealer.sv
// Producer side of the bell-game card path: deals LFSR-derived cards to two
// piles on a fixed cadence, freezes while a bell press resolves, counts rounds.
module card_dealer #(
  parameter logic [15:0] DEAL_INTERVAL = 16'd50000,
  parameter logic [7:0]  ROUNDS        = 8'd10,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hold,
  input  logic       finish,
  output logic [1:0] c1,
  output logic [2:0] n1,
  output logic [1:0] c2,
  output logic [2:0] n2,
  output logic [7:0] count,
  output logic       card_valid,
  output logic       turn,
  output logic [7:0] round_num,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_WAIT,
    S_FROZEN,
    S_CLEAR
  } state_t;

  state_t      state, state_next;
  logic [15:0] lfsr, lfsr_next;
  logic [15:0] timer, timer_next;
  logic [1:0]  c1_next, c2_next;
  logic [2:0]  n1_next, n2_next;
  logic [7:0]  count_next, round_next;
  logic        valid_next, turn_next, over_next;

  // Card number is (v mod 5) + 1 for a 3-bit v.
  function automatic logic [2:0] card_number(input logic [2:0] v);
    card_number = (v >= 3'd5) ? v - 3'd4 : v + 3'd1;
  endfunction

  assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      lfsr       <= SEED;
      timer      <= '0;
      c1         <= '0;
      n1         <= '0;
      c2         <= '0;
      n2         <= '0;
      count      <= '0;
      card_valid <= 1'b0;
      turn       <= 1'b0;
      round_num  <= '0;
      game_over  <= 1'b0;
    end else begin
      state      <= state_next;
      lfsr       <= lfsr_next;
      timer      <= timer_next;
      c1         <= c1_next;
      n1         <= n1_next;
      c2         <= c2_next;
      n2         <= n2_next;
      count      <= count_next;
      card_valid <= valid_next;
      turn       <= turn_next;
      round_num  <= round_next;
      game_over  <= over_next;
    end
  end

  always_comb begin
    state_next = state;
    timer_next = timer;
    c1_next    = c1;
    n1_next    = n1;
    c2_next    = c2;
    n2_next    = n2;
    count_next = count;
    valid_next = card_valid;
    turn_next  = turn;
    round_next = round_num;
    over_next  = game_over;

    case (state)
      S_IDLE: begin
        if (start) begin
          over_next = 1'b0;
          if (game_over) round_next = '0;
          state_next = S_FIRST;
        end
      end

      S_FIRST: begin
        c1_next    = lfsr[1:0];
        n1_next    = card_number(lfsr[4:2]);
        c2_next    = lfsr[6:5];
        n2_next    = card_number(lfsr[9:7]);
        count_next = 8'd2;
        valid_next = 1'b1;
        turn_next  = 1'b0;
        timer_next = DEAL_INTERVAL - 16'd1;
        state_next = S_WAIT;
      end

      S_WAIT: begin
        // A pending bell press outranks a deal due in the same cycle.
        if (hold) begin
          state_next = S_FROZEN;
        end else if (timer == '0) begin
          if (!turn) begin
            c1_next = lfsr[1:0];
            n1_next = card_number(lfsr[4:2]);
          end else begin
            c2_next = lfsr[1:0];
            n2_next = card_number(lfsr[4:2]);
          end
          turn_next  = ~turn;
          count_next = (count == '1) ? count : count + 8'd1;
          timer_next = DEAL_INTERVAL - 16'd1;
        end else begin
          timer_next = timer - 16'd1;
        end
      end

      S_FROZEN: begin
        if (finish) state_next = S_CLEAR;
      end

      S_CLEAR: begin
        count_next = '0;
        valid_next = 1'b0;
        round_next = round_num + 8'd1;
        if (round_next == ROUNDS) begin
          over_next  = 1'b1;
          state_next = S_IDLE;
        end else begin
          state_next = S_FIRST;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: LFSR reference model, card mapping table,
// per-cycle vector table for round/game sequencing, hand-written corner cases.
module tb_card_dealer;

  localparam logic [15:0] DI   = 16'd4;
  localparam logic [7:0]  RNDS = 8'd2;
  localparam logic [15:0] SD   = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       hold = 1'b0;
  logic       finish = 1'b0;
  logic [1:0] c1, c2;
  logic [2:0] n1, n2;
  logic [7:0] count, round_num;
  logic       card_valid, turn, game_over;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [15:0] m_lfsr;
  logic [15:0] L;
  logic [1:0]  ec1, ec2;
  logic [2:0]  en1, en2;

  typedef struct packed {
    logic       st;
    logic       hd;
    logic       fn;
    logic [7:0] cnt;
    logic       vld;
    logic       trn;
    logic [7:0] rnd;
    logic       go;
  } vec_t;

  vec_t tbl [16];

  card_dealer #(.DEAL_INTERVAL(DI), .ROUNDS(RNDS), .SEED(SD)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .finish(finish),
    .c1(c1), .n1(n1), .c2(c2), .n2(n2), .count(count),
    .card_valid(card_valid), .turn(turn), .round_num(round_num),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Reference LFSR: right-shifting Fibonacci form of taps 16,14,13,11.
  always @(posedge clk) begin
    if (!rst) m_lfsr <= SD;
    else      m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  function automatic logic [2:0] num_of(input logic [2:0] v);
    case (v)
      3'd0: num_of = 3'd1;
      3'd1: num_of = 3'd2;
      3'd2: num_of = 3'd3;
      3'd3: num_of = 3'd4;
      3'd4: num_of = 3'd5;
      3'd5: num_of = 3'd1;
      3'd6: num_of = 3'd2;
      default: num_of = 3'd3;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_cards(input string name);
    chk({name, ".c1"}, 32'(c1), 32'(ec1));
    chk({name, ".n1"}, 32'(n1), 32'(en1));
    chk({name, ".c2"}, 32'(c2), 32'(ec2));
    chk({name, ".n2"}, 32'(n2), 32'(en2));
  endtask

  task automatic chk_ctl(input string name, input logic [7:0] cnt, input logic vld,
                         input logic trn, input logic [7:0] rnd, input logic go);
    chk({name, ".count"}, 32'(count), 32'(cnt));
    chk({name, ".valid"}, 32'(card_valid), 32'(vld));
    chk({name, ".turn"}, 32'(turn), 32'(trn));
    chk({name, ".round"}, 32'(round_num), 32'(rnd));
    chk({name, ".game_over"}, 32'(game_over), 32'(go));
  endtask

  task automatic deal_pair();
    ec1 = L[1:0];
    en1 = num_of(L[4:2]);
    ec2 = L[6:5];
    en2 = num_of(L[9:7]);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 8'd2, 1'b1, 1'b0, 8'd1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 8'd2, 1'b1, 1'b0, 8'd1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd2, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd2, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 8'd2, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd2, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 8'd0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 8'd0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0, 8'd0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 8'd0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 8'd3, 1'b1, 1'b1, 8'd0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 8'd3, 1'b1, 1'b1, 8'd0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 8'd3, 1'b1, 1'b1, 8'd0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 8'd3, 1'b1, 1'b1, 8'd0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0, 8'd0, 1'b0};

    ec1 = '0; en1 = '0; ec2 = '0; en2 = '0;
    tick();
    tick();
    chk_cards("reset");
    chk_ctl("reset", 8'd0, 1'b0, 1'b0, 8'd0, 1'b0);

    // First game: start, two-card deal out of FIRST.
    rst = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("first_pre.count", 32'(count), 32'd0);
    L = m_lfsr;
    tick();
    deal_pair();
    chk_cards("first");
    chk_ctl("first", 8'd2, 1'b1, 1'b0, 8'd0, 1'b0);
    chk("first.n1_range", 32'(n1 >= 3'd1 && n1 <= 3'd5), 32'd1);
    chk("first.n2_range", 32'(n2 >= 3'd1 && n2 <= 3'd5), 32'd1);

    // Three single deals: P1, P2, P1.
    for (int d = 0; d < 3; d++) begin
      tick(); tick(); tick();
      chk("deal_pre.count", 32'(count), 32'(8'd2 + 8'(d)));
      L = m_lfsr;
      tick();
      if (d == 1) begin
        ec2 = L[1:0];
        en2 = num_of(L[4:2]);
      end else begin
        ec1 = L[1:0];
        en1 = num_of(L[4:2]);
      end
      chk_cards("deal");
      chk_ctl("deal", 8'd3 + 8'(d), 1'b1, (d != 1), 8'd0, 1'b0);
    end

    // hold lands on the timer==0 cycle: no deal, frozen.
    tick(); tick(); tick();
    hold = 1'b1;
    tick();
    chk_cards("hold_edge");
    chk_ctl("hold_edge", 8'd5, 1'b1, 1'b1, 8'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("frozen.count", 32'(count), 32'd5);
      chk("frozen.turn", 32'(turn), 32'd1);
    end
    chk_cards("frozen");
    hold = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("hold_drop.count", 32'(count), 32'd5);
    end
    chk_cards("hold_drop");

    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk_ctl("clear_state", 8'd5, 1'b1, 1'b1, 8'd0, 1'b0);
    tick();
    chk_ctl("after_clear", 8'd0, 1'b0, 1'b1, 8'd1, 1'b0);
    chk_cards("after_clear");
    L = m_lfsr;
    tick();
    deal_pair();
    chk_cards("round2_first");
    chk_ctl("round2_first", 8'd2, 1'b1, 1'b0, 8'd1, 1'b0);

    // Round 2 to game over, ignored inputs in IDLE, restart and resume dealing.
    for (int i = 0; i < 16; i++) begin
      start  = tbl[i].st;
      hold   = tbl[i].hd;
      finish = tbl[i].fn;
      tick();
      chk($sformatf("vec%0d.count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d.valid", i), 32'(card_valid), 32'(tbl[i].vld));
      chk($sformatf("vec%0d.turn", i), 32'(turn), 32'(tbl[i].trn));
      chk($sformatf("vec%0d.round", i), 32'(round_num), 32'(tbl[i].rnd));
      chk($sformatf("vec%0d.game_over", i), 32'(game_over), 32'(tbl[i].go));
    end
    start = 1'b0; hold = 1'b0; finish = 1'b0;

    // Reset in WAIT with count 7.
    for (int i = 0; i < 12; i++) tick();
    chk("pre_reset.count", 32'(count), 32'd7);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    ec1 = '0; en1 = '0; ec2 = '0; en2 = '0;
    chk_cards("mid_reset");
    chk_ctl("mid_reset", 8'd0, 1'b0, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk_ctl("idle_after_reset", 8'd0, 1'b0, 1'b0, 8'd0, 1'b0);

    // Saturation: 300 single deals.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("sat_first.count", 32'(count), 32'd2);
    for (int k = 1; k <= 300; k++) begin
      tick(); tick(); tick(); tick();
      chk($sformatf("sat%0d.count", k), 32'(count), (k + 2 > 255) ? 32'd255 : 32'(k + 2));
    end
    chk("sat_end.turn", 32'(turn), 32'd0);
    chk("sat_end.valid", 32'(card_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
Producer side of the bell-game card path. Deals pseudo-random cards to the two players' face-up piles on a fixed cadence and drives c1/n1 and c2/n2 into the answer checker. Drives the pile count into the score controller. Freezes while a bell press is being resolved, then starts a new round. Sequences a fixed number of rounds and flags game over.

Parameters:
DEAL_INTERVAL, 16'd50000, clock cycles between successive deals (must be >= 2)
ROUNDS, 8'd10, number of rounds per game (must be >= 1)
SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low
start  input  1  begin a game; honoured only in IDLE
hold  input  1  a bell press is latched (savewho1 | savewho2)
finish  input  1  score controller has resolved the press
c1  output  2  player-1 top card colour
n1  output  3  player-1 top card number, 1..5 when card_valid
c2  output  2  player-2 top card colour
n2  output  3  player-2 top card number, 1..5 when card_valid
count  output  8  cards dealt in current round, saturating
card_valid  output  1  cards on c1/n1/c2/n2 are live
turn  output  1  player receiving the next single deal (0 = P1, 1 = P2)
round_num  output  8  rounds completed this game
game_over  output  1  high after the final round until the next start

Behaviour:
- Reset (rst == 0 at posedge): state IDLE; lfsr = SEED; c1, n1, c2, n2 = 0; count = 0; card_valid = 0; turn = 0; round_num = 0; game_over = 0; timer = 0. Reset mid-game aborts immediately, with no completion pulse.
- LFSR: 16-bit Fibonacci, taps 16, 14, 13, 11. Shifts every non-reset cycle, including in IDLE.
- Card derivation from the current lfsr value: colour = lfsr[1:0]; number = (lfsr[4:2] mod 5) + 1. The mapping for lfsr[4:2] values 0..7 is 1, 2, 3, 4, 5, 1, 2, 3.
- For a two-card deal, P1 uses lfsr[4:0] and P2 uses lfsr[9:5] with the same mapping.
- States: IDLE, FIRST, WAIT, FROZEN, CLEAR.
- IDLE:
  - Outputs hold their values.
  - If start == 1: game_over <= 0. If game_over was 1, round_num <= 0 first. Next state FIRST.
- FIRST (1 cycle):
  - Deal both cards: count <= 2; card_valid <= 1; turn <= 0.
  - timer <= DEAL_INTERVAL - 1. Next state WAIT.
- WAIT:
  - If hold == 1: next state FROZEN; timer and cards unchanged. hold has priority over a deal in the same cycle.
  - Else if timer == 0: deal one card to the player selected by turn; turn toggles; count <= min(count + 1, 255); timer <= DEAL_INTERVAL - 1.
  - Else: timer decrements.
  - Deal latency: the new card is visible the cycle after the timer == 0 cycle.
- FROZEN:
  - Cards, count and timer are frozen.
  - On finish == 1: next state CLEAR.
  - hold dropping without finish: stay in FROZEN.
- CLEAR (1 cycle):
  - count <= 0; card_valid <= 0; round_num <= round_num + 1.
  - If round_num + 1 == ROUNDS: next state IDLE and game_over <= 1.
  - Else: next state FIRST.
- count is held stable from the deal before hold through FROZEN, so the score controller samples a stable pile value.
- start outside IDLE is ignored. finish outside FROZEN is ignored.
- round_num wraps modulo 256. With ROUNDS <= 255 the wrap is unreachable.

Test Plan:
- Reset with SEED = 16'hACE1, then start pulse -> 1 cycle later card_valid = 1, count = 2, c1/n1 and c2/n2 match the mapping of the lfsr value at FIRST; both numbers in 1..5.
- DEAL_INTERVAL = 4, no hold -> one new card every 4 cycles; P1 updates, then P2, then P1; count = 3, 4, 5; the other player's card stays unchanged.
- hold asserted in the same cycle timer == 0 -> no deal, state FROZEN, count unchanged; holding 20 cycles leaves all outputs constant.
- In FROZEN, finish pulses -> next cycle count = 0, card_valid = 0, round_num increments; the following cycle FIRST deals again with count = 2.
- ROUNDS = 2, two hold/finish cycles -> game_over = 1, state IDLE, round_num = 2. A later start sets game_over = 0 and round_num = 0, and dealing resumes.
- Reset asserted in WAIT with count = 7 -> next cycle all outputs at reset values. Run 300 deals with no hold -> count saturates at 255 and does not wrap.
